regfile_mp: RTL and testbench



---
 rtl/regfile_mp.sv | 110 +++++++++++
 tb/tb_regfile_mp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-port register file with registered reads, write-first bypass,
// optional hardwired-zero entry 0 and a post-reset clear sweep.
module regfile_mp #(
    parameter int WordLen    = 32,
    parameter int WordCount  = 32,
    parameter int ReadPorts  = 2,
    parameter int WritePorts = 1,
    parameter int ZeroReg    = 1,
    localparam int AW = (WordCount > 1) ? $clog2(WordCount) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ReadPorts*AW-1:0]       readRegister,
    output logic [ReadPorts*WordLen-1:0]  readData,
    input  logic [WritePorts-1:0]         regWrite,
    input  logic [WritePorts*AW-1:0]      writeRegister,
    input  logic [WritePorts*WordLen-1:0] writeData,
    output logic                          ready
);

    localparam logic [AW:0] WordCountExt = (AW+1)'(WordCount);
    localparam logic [AW:0] LastIdx      = (AW+1)'(WordCount - 1);

    typedef enum logic {sClear, sRun} stateT;

    stateT       state, stateNext;
    logic [AW:0] ptr, ptrNext;
    logic        readyNext;

    logic [WordLen-1:0] mem [WordCount];

    logic               wrEn    [WritePorts];
    logic [AW-1:0]      wrAddr  [WritePorts];
    logic [WordLen-1:0] wrDat   [WritePorts];
    logic [AW-1:0]      rdAddr  [ReadPorts];
    logic [WordLen-1:0] readNext[ReadPorts];

    function automatic logic addrUsable(input logic [AW-1:0] a);
        return ({1'b0, a} < WordCountExt) && !((ZeroReg != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= sClear;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            state <= stateNext;
            ptr   <= ptrNext;
            ready <= readyNext;
        end
    end

    always_comb begin
        stateNext = state;
        ptrNext   = ptr;
        readyNext = ready;
        if (state == sClear) begin
            ptrNext = ptr + 1'b1;
            if (ptr == LastIdx) begin
                stateNext = sRun;
                readyNext = 1'b1;
            end
        end
    end

    always_comb begin
        for (int unsigned w = 0; w < WritePorts; w++) begin
            wrAddr[w] = writeRegister[w*AW +: AW];
            wrDat[w]  = writeData[w*WordLen +: WordLen];
            wrEn[w]   = regWrite[w] && (state == sRun) && addrUsable(wrAddr[w]);
        end
    end

    // Bypass scans ports in ascending order so the highest-numbered writer wins,
    // matching the write ordering into the array below.
    always_comb begin
        for (int unsigned p = 0; p < ReadPorts; p++) begin
            rdAddr[p]   = readRegister[p*AW +: AW];
            readNext[p] = addrUsable(rdAddr[p]) ? mem[rdAddr[p]] : '0;
            for (int unsigned w = 0; w < WritePorts; w++) begin
                if (wrEn[w] && (wrAddr[w] == rdAddr[p]))
                    readNext[p] = wrDat[w];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == sClear) begin
                mem[ptr[AW-1:0]] <= '0;
            end else begin
                for (int unsigned w = 0; w < WritePorts; w++) begin
                    if (wrEn[w])
                        mem[wrAddr[w]] <= wrDat[w];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < ReadPorts; p++) begin
            if (rst || (state == sClear))
                readData[p*WordLen +: WordLen] <= '0;
            else
                readData[p*WordLen +: WordLen] <= readNext[p];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: three instances (defaults with two write ports,
// the same without the zero register, and a 16x24 three-read-port variant).
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;

    logic [9:0]  rr0;
    logic [63:0] rd0, rd1;
    logic [1:0]  we0;
    logic [9:0]  wr0;
    logic [63:0] wd0;
    logic        rdy0, rdy1;

    logic [14:0] rr2;
    logic [47:0] rd2;
    logic [0:0]  we2;
    logic [4:0]  wr2;
    logic [15:0] wd2;
    logic        rdy2;

    always #5 clk = ~clk;

    regfile_mp #(.WordLen(32), .WordCount(32), .ReadPorts(2), .WritePorts(2), .ZeroReg(1)) u0 (
        .clk(clk), .rst(rst), .readRegister(rr0), .readData(rd0), .regWrite(we0),
        .writeRegister(wr0), .writeData(wd0), .ready(rdy0));

    regfile_mp #(.WordLen(32), .WordCount(32), .ReadPorts(2), .WritePorts(2), .ZeroReg(0)) u1 (
        .clk(clk), .rst(rst), .readRegister(rr0), .readData(rd1), .regWrite(we0),
        .writeRegister(wr0), .writeData(wd0), .ready(rdy1));

    regfile_mp #(.WordLen(16), .WordCount(24), .ReadPorts(3), .WritePorts(1), .ZeroReg(1)) u2 (
        .clk(clk), .rst(rst), .readRegister(rr2), .readData(rd2), .regWrite(we2),
        .writeRegister(wr2), .writeData(wd2), .ready(rdy2));

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } expT;

    expT sb[$];

    int nChecks = 0;
    int nPass   = 0;
    int cyc     = 0;

    logic [31:0] m0[32];
    logic [31:0] m1[32];
    logic [15:0] m2[24];
    bit run0 = 1'b0, run2 = 1'b0;
    int cnt0 = 0, cnt2 = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] observed(input int sel);
        case (sel)
            0: return rd0[31:0];
            1: return rd0[63:32];
            2: return rd1[31:0];
            3: return rd1[63:32];
            4: return {16'h0, rd2[15:0]};
            5: return {16'h0, rd2[31:16]};
            6: return {16'h0, rd2[47:32]};
            7: return {31'h0, rdy0};
            8: return {31'h0, rdy1};
            default: return {31'h0, rdy2};
        endcase
    endfunction

    task automatic pushExp(input string tag, input int sel, input logic [31:0] e);
        sb.push_back('{tag, sel, e});
    endtask

    // Predict the post-edge outputs from the inputs currently driven, then clock and score.
    task automatic runCycle();
        logic [4:0] a;
        expT x;
        if (rst) begin
            run0 = 1'b0; cnt0 = 0;
            for (int p = 0; p < 2; p++) begin
                pushExp($sformatf("c%0d rd0[%0d]", cyc, p), p, 32'h0);
                pushExp($sformatf("c%0d rd1[%0d]", cyc, p), 2 + p, 32'h0);
            end
        end else if (!run0) begin
            for (int p = 0; p < 2; p++) begin
                pushExp($sformatf("c%0d rd0[%0d]", cyc, p), p, 32'h0);
                pushExp($sformatf("c%0d rd1[%0d]", cyc, p), 2 + p, 32'h0);
            end
            cnt0++;
            if (cnt0 == 32) begin
                run0 = 1'b1;
                for (int i = 0; i < 32; i++) begin m0[i] = '0; m1[i] = '0; end
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (we0[w]) begin
                    a = wr0[w*5 +: 5];
                    if (a != 0) m0[a] = wd0[w*32 +: 32];
                    m1[a] = wd0[w*32 +: 32];
                end
            end
            for (int p = 0; p < 2; p++) begin
                a = rr0[p*5 +: 5];
                pushExp($sformatf("c%0d rd0[%0d]", cyc, p), p, m0[a]);
                pushExp($sformatf("c%0d rd1[%0d]", cyc, p), 2 + p, m1[a]);
            end
        end
        pushExp($sformatf("c%0d ready0", cyc), 7, {31'h0, run0});
        pushExp($sformatf("c%0d ready1", cyc), 8, {31'h0, run0});

        if (rst) begin
            run2 = 1'b0; cnt2 = 0;
            for (int p = 0; p < 3; p++) pushExp($sformatf("c%0d rd2[%0d]", cyc, p), 4 + p, 32'h0);
        end else if (!run2) begin
            for (int p = 0; p < 3; p++) pushExp($sformatf("c%0d rd2[%0d]", cyc, p), 4 + p, 32'h0);
            cnt2++;
            if (cnt2 == 24) begin
                run2 = 1'b1;
                for (int i = 0; i < 24; i++) m2[i] = '0;
            end
        end else begin
            if (we2[0] && wr2 < 24 && wr2 != 0) m2[wr2] = wd2;
            for (int p = 0; p < 3; p++) begin
                a = rr2[p*5 +: 5];
                pushExp($sformatf("c%0d rd2[%0d]", cyc, p), 4 + p, (a < 24) ? {16'h0, m2[a]} : 32'h0);
            end
        end
        pushExp($sformatf("c%0d ready2", cyc), 9, {31'h0, run2});

        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            checkEq(x.tag, observed(x.sel), x.exp);
        end
        cyc++;
    endtask

    task automatic idle();
        we0 = '0; wr0 = '0; wd0 = '0; rr0 = '0;
        we2 = '0; wr2 = '0; wd2 = '0; rr2 = '0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        // Write x5 = 0xDEAD through reset and the whole sweep; none of it may land.
        we0 = 2'b01; wr0 = {5'd0, 5'd5}; wd0 = {32'h0, 32'h0000DEAD};
        we2 = 1'b1;  wr2 = 5'd5;         wd2 = 16'hDEAD;
        rr0 = {5'd5, 5'd5};
        runCycle();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            we2 = (i < 24);
            runCycle();
        end
        idle();
        rr0 = {5'd5, 5'd5};
        rr2 = {5'd5, 5'd5, 5'd5};
        runCycle();

        // Reset re-asserted ten cycles into the sweep restarts it from zero.
        rst = 1'b1; runCycle();
        rst = 1'b0;
        repeat (10) runCycle();
        rst = 1'b1; runCycle();
        rst = 1'b0;
        repeat (32) runCycle();

        // Same-cycle double write to x3 with a read of x3: port 1 wins, bypassed.
        we0 = 2'b11; wr0 = {5'd3, 5'd3}; wd0 = {32'h00002222, 32'h00001111};
        rr0 = {5'd7, 5'd3};
        runCycle();
        idle();
        rr0 = {5'd3, 5'd3};
        runCycle();

        // x0 write while both lanes read x0.
        we0 = 2'b01; wr0 = {5'd0, 5'd0}; wd0 = {32'h0, 32'hFFFFFFFF};
        rr0 = {5'd0, 5'd0};
        runCycle();
        idle();
        rr0 = {5'd0, 5'd0};
        runCycle();

        // Mixed random traffic on the 32-entry instances.
        for (int i = 0; i < 40; i++) begin
            we0 = 2'($urandom_range(0, 3));
            wr0 = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            wd0 = {32'($urandom), 32'($urandom)};
            rr0 = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            runCycle();
        end
        idle();

        // 16x24 instance: fill, random reads, out-of-range access.
        for (int i = 0; i < 24; i++) begin
            we2 = 1'b1; wr2 = 5'(i); wd2 = 16'(i * 257);
            rr2 = {5'($urandom_range(0, 23)), 5'($urandom_range(0, 23)), 5'(i)};
            runCycle();
        end
        idle();
        for (int i = 0; i < 20; i++) begin
            rr2 = {5'($urandom_range(0, 23)), 5'($urandom_range(0, 23)), 5'($urandom_range(0, 23))};
            runCycle();
        end
        we2 = 1'b1; wr2 = 5'd30; wd2 = 16'hBEEF;
        rr2 = {5'd30, 5'd31, 5'd30};
        runCycle();
        idle();
        for (int j = 0; j < 8; j++) begin
            rr2 = {5'(j*3 + 2), 5'(j*3 + 1), 5'(j*3)};
            runCycle();
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
